// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared types and widths for the VDP VRAM arbiter
package vdp_pkg;

   localparam int VRAM_AW = 14;
   localparam int VRAM_DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      READ_WAIT
   } arb_state_t;

   typedef struct packed {
      logic [VRAM_AW-1:0] addr;
      logic [VRAM_DW-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/vdp_wr_fifo.sv
// rtl/vdp_wr_fifo.sv - posted-write FIFO holding {addr,data} CPU writes
module vdp_wr_fifo
   import vdp_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_L,
   input  logic                        push,
   input  wr_entry_t                   push_entry,
   input  logic                        pop,
   output wr_entry_t                   head,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   // One extra pointer bit distinguishes full from empty when the indices match.
   localparam int PW = $clog2(FIFO_DEPTH) + 1;

   wr_entry_t       mem [FIFO_DEPTH];
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
   assign empty   = (wptr == rptr);
   assign count   = wptr - rptr;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rptr[PW-2:0]];

   // Pointers advance modulo 2*FIFO_DEPTH; reset empties the queue.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PW'(1);
         if (do_pop)  rptr <= rptr + PW'(1);
      end
   end

   // Entry storage; contents are don't-care until the write pointer passes them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[PW-2:0]] <= push_entry;
   end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// rtl/vdp_vram_arbiter.sv - CPU/display VRAM port arbiter with posted writes; optional VDP_ARB_STATS_EN adds stall_cnt
module vdp_vram_arbiter
   import vdp_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_L,
   input  logic               disp_go,
   input  logic               screen_busy,
   input  logic               cpu_wr,
   input  logic               cpu_rd,
   input  logic [VRAM_AW-1:0] cpu_addr,
   input  logic [VRAM_DW-1:0] cpu_wdata,
   output logic               cpu_ready,
   output logic               cpu_rvalid,
   output logic [VRAM_DW-1:0] cpu_rdata,
   output logic               vram_en,
   output logic               vram_we,
   output logic [VRAM_AW-1:0] vram_addr,
   output logic [VRAM_DW-1:0] vram_wdata,
   input  logic [VRAM_DW-1:0] vram_rdata,
   output logic               fifo_full,
   output logic               fifo_empty
`ifdef VDP_ARB_STATS_EN
   ,
   output logic [15:0]        stall_cnt
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH) + 1;

   arb_state_t         state;
   logic [VRAM_AW-1:0] rd_addr_q;
   logic [VRAM_DW-1:0] rdata_q;
   logic               wr_acc;
   logic               rd_acc;
   logic               pop;
   logic [PW-1:0]      count;
   wr_entry_t          head;
   wr_entry_t          push_entry;
   logic               unused_screen_busy;

   // Display fetch timing is fully expressed by disp_go; the window flag is informational here.
   assign unused_screen_busy = screen_busy;

   // Writes win over reads; reads wait for an empty FIFO and an idle port so they see all prior writes.
   assign wr_acc     = rst_L && cpu_wr && !fifo_full;
   assign rd_acc     = rst_L && cpu_rd && !cpu_wr && fifo_empty && (state == IDLE) && !disp_go;
   assign cpu_ready  = wr_acc || rd_acc;
   assign push_entry = '{addr: cpu_addr, data: cpu_wdata};

   // A display slot always steals the port, so a WRITE cycle under disp_go neither strobes nor pops.
   assign pop        = (state == WRITE) && !disp_go;
   assign vram_we    = pop;
   assign vram_en    = pop || ((state == READ) && !disp_go);
   assign vram_addr  = (state == WRITE) ? head.addr :
                       (state == READ)  ? rd_addr_q : '0;
   assign vram_wdata = (state == WRITE) ? head.data : '0;
   assign cpu_rvalid = (state == READ_WAIT);
   assign cpu_rdata  = (state == READ_WAIT) ? vram_rdata : rdata_q;

   vdp_wr_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk        (clk),
      .rst_L      (rst_L),
      .push       (wr_acc),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (count)
   );

   // Port sequencer: drain posted writes, else serve one read with a fixed 2-cycle turnaround.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state     <= IDLE;
         rd_addr_q <= '0;
         rdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty && !disp_go) begin
                  state <= WRITE;
               end else if (rd_acc) begin
                  state     <= READ;
                  rd_addr_q <= cpu_addr;
               end
            end
            WRITE: begin
               if (disp_go)
                  state <= IDLE;
               else if ((count > PW'(1)) || wr_acc)
                  state <= WRITE;
               else
                  state <= IDLE;
            end
            READ: begin
               if (!disp_go) state <= READ_WAIT;
            end
            READ_WAIT: begin
               rdata_q <= vram_rdata;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VDP_ARB_STATS_EN
   // Saturating count of cycles where posted writes are held off by display fetches.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L)
         stall_cnt <= '0;
      else if (!fifo_empty && disp_go && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// tb/tb_vdp_vram_arbiter.sv - directed self-checking bench with a queue-based scoreboard for vdp_vram_arbiter
module tb_vdp_vram_arbiter;
   import vdp_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_L;
   logic        disp_go;
   logic        screen_busy;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ready;
   logic        cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic        vram_en;
   logic        vram_we;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata;
   logic        fifo_full;
   logic        fifo_empty;
`ifdef VDP_ARB_STATS_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   vdp_vram_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_L       (rst_L),
      .disp_go     (disp_go),
      .screen_busy (screen_busy),
      .cpu_wr      (cpu_wr),
      .cpu_rd      (cpu_rd),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ready   (cpu_ready),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_rdata   (cpu_rdata),
      .vram_en     (vram_en),
      .vram_we     (vram_we),
      .vram_addr   (vram_addr),
      .vram_wdata  (vram_wdata),
      .vram_rdata  (vram_rdata),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty)
`ifdef VDP_ARB_STATS_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // VRAM behind the CPU port: synchronous write, 1-cycle read latency.
   logic [7:0] ram [16384];
   logic [7:0] rdata_r = 8'h00;
   assign vram_rdata = rdata_r;
   always @(posedge clk) begin
      if (vram_en && vram_we) ram[vram_addr] = vram_wdata;
      if (vram_en && !vram_we) rdata_r <= ram[vram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: posted writes are a FIFO of CPU writes in program order; reads return
   // the last value the CPU wrote and complete exactly 2 cycles after acceptance.
   wr_entry_t   mq [$];
   logic [7:0]  ref_mem [16384];
   bit          rd_pend;
   int          rd_due;
   logic [7:0]  rd_exp;
   logic [13:0] rd_addr_m;
   int          acc_wr_cyc, acc_rd_cyc, rv_cyc, rv_cnt, we_cnt, last_we_cyc;
   logic [7:0]  rv_data;
   logic [13:0] last_we_addr;
   logic [7:0]  last_we_data;
   int          we_cycs [$];
   int          stall_m;
   bit          exp_wr, exp_rd, exp_rv;

   always @(negedge clk) begin
      if (!rst_L) begin
         chk("rst_ready", 32'(cpu_ready), 0);
         chk("rst_rvalid", 32'(cpu_rvalid), 0);
         chk("rst_rdata", 32'(cpu_rdata), 0);
         chk("rst_vram_en", 32'(vram_en), 0);
         chk("rst_vram_we", 32'(vram_we), 0);
         chk("rst_vram_addr", 32'(vram_addr), 0);
         chk("rst_vram_wdata", 32'(vram_wdata), 0);
         chk("rst_full", 32'(fifo_full), 0);
         chk("rst_empty", 32'(fifo_empty), 1);
`ifdef VDP_ARB_STATS_EN
         chk("rst_stall", 32'(stall_cnt), 0);
`endif
         mq.delete();
         rd_pend = 0;
         stall_m = 0;
      end else begin
         exp_wr = cpu_wr && (mq.size() < DEPTH);
         exp_rd = cpu_rd && !cpu_wr && (mq.size() == 0) && !rd_pend && !disp_go;
         chk("ready", 32'(cpu_ready), 32'(exp_wr || exp_rd));
         chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
         chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
         if (disp_go) chk("disp_priority", 32'(vram_en), 0);
`ifdef VDP_ARB_STATS_EN
         chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
         if (mq.size() > 0 && disp_go && stall_m < 65535) stall_m++;
`endif
         exp_rv = rd_pend && (cyc == rd_due);
         chk("rvalid", 32'(cpu_rvalid), 32'(exp_rv));
         if (exp_rv) begin
            chk("rdata", 32'(cpu_rdata), 32'(rd_exp));
            rd_pend = 0;
            rv_cyc  = cyc;
            rv_data = cpu_rdata;
            rv_cnt++;
         end
         if (vram_en && !vram_we) begin
            chk("rd_port_pending", 32'(rd_pend), 1);
            chk("rd_port_addr", 32'(vram_addr), 32'(rd_addr_m));
         end
         if (vram_en && vram_we) begin
            chk("wr_has_entry", 32'(mq.size() > 0), 1);
            if (mq.size() > 0) begin
               chk("wr_addr", 32'(vram_addr), 32'(mq[0].addr));
               chk("wr_data", 32'(vram_wdata), 32'(mq[0].data));
               void'(mq.pop_front());
            end
            last_we_addr = vram_addr;
            last_we_data = vram_wdata;
            last_we_cyc  = cyc;
            we_cycs.push_back(cyc);
            we_cnt++;
         end
         if (exp_wr) begin
            mq.push_back('{addr: cpu_addr, data: cpu_wdata});
            ref_mem[cpu_addr] = cpu_wdata;
            acc_wr_cyc = cyc;
         end
         if (exp_rd) begin
            rd_pend    = 1;
            rd_due     = cyc + 2;
            rd_exp     = ref_mem[cpu_addr];
            rd_addr_m  = cpu_addr;
            acc_rd_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_wr(input logic [13:0] a, input logic [7:0] d);
      bit ok = 0;
      cpu_wr = 1; cpu_addr = a; cpu_wdata = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         ok = cpu_ready;
         tick();
      end
      cpu_wr = 0;
      chk("wr_accepted", 32'(ok), 1);
   endtask

   task automatic do_rd(input logic [13:0] a);
      bit ok = 0;
      cpu_rd = 1; cpu_addr = a;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         ok = cpu_ready;
         tick();
      end
      cpu_rd = 0;
      chk("rd_accepted", 32'(ok), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int r, n0, rv0, we0;
      logic rdy [5];
      for (int i = 0; i < 16384; i++) begin
         ram[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      rst_L = 0; disp_go = 0; screen_busy = 0; cpu_wr = 0; cpu_rd = 0;
      cpu_addr = '0; cpu_wdata = '0;
      rv_cnt = 0; we_cnt = 0; stall_m = 0;
      repeat (3) tick();
      chk("init_empty", 32'(fifo_empty), 1);
      rst_L = 1;
      repeat (2) tick();

      // Posted write lands on the port 2 cycles after acceptance.
      do_wr(14'h3800, 8'h5A);
      repeat (4) tick();
      chk("s1_addr", 32'(last_we_addr), 32'h3800);
      chk("s1_data", 32'(last_we_data), 32'h5A);
      chk("s1_latency", 32'(last_we_cyc - acc_wr_cyc), 2);

      // Read-after-write waits for the drain, then returns the written byte.
      screen_busy = 1;
      do_wr(14'h0010, 8'h11);
      do_rd(14'h0010);
      repeat (4) tick();
      chk("s2_rd_after_drain", 32'(acc_rd_cyc - acc_wr_cyc), 3);
      chk("s2_rd_latency", 32'(rv_cyc - acc_rd_cyc), 2);
      chk("s2_rdata", 32'(rv_data), 32'h11);

      // Display owns the port for 10 cycles; only DEPTH writes fit.
      disp_go = 1;
      for (int k = 0; k < 5; k++) begin
         cpu_wr = 1; cpu_addr = 14'h0100 + 14'(k); cpu_wdata = 8'hA0 + 8'(k);
         #1;
         rdy[k] = cpu_ready;
         tick();
      end
      cpu_wr = 0;
      for (int k = 0; k < 5; k++) chk("s3_ready", 32'(rdy[k]), 32'(k < 4));
      repeat (5) tick();
      chk("s3_full", 32'(fifo_full), 1);
      n0 = we_cycs.size();
      disp_go = 0;
      r = cyc;
      repeat (6) tick();
      chk("s3_drain_count", 32'(we_cycs.size() - n0), 4);
      if (we_cycs.size() >= n0 + 4) begin
         chk("s3_first_pop", 32'(we_cycs[n0]), 32'(r + 1));
         chk("s3_back_to_back", 32'(we_cycs[n0+3] - we_cycs[n0]), 3);
      end

      // disp_go arrives in the WRITE cycle: pop suppressed, entry written once afterwards.
      screen_busy = 0;
      we0 = we_cnt;
      do_wr(14'h0200, 8'h77);
      tick();
      disp_go = 1;
      repeat (3) tick();
      chk("s4_held", 32'(we_cnt - we0), 0);
      disp_go = 0;
      r = cyc;
      repeat (4) tick();
      chk("s4_once", 32'(we_cnt - we0), 1);
      chk("s4_when", 32'(last_we_cyc), 32'(r + 1));
      chk("s4_ram", 32'(ram[14'h0200]), 32'h77);

      // Simultaneous write and read: write first, read after the drain.
      cpu_wr = 1; cpu_rd = 1; cpu_addr = 14'h0300; cpu_wdata = 8'h33;
      #1;
      chk("s5_wr_wins", 32'(cpu_ready), 1);
      tick();
      cpu_wr = 0;
      do_rd(14'h0300);
      repeat (4) tick();
      chk("s5_rd_after_drain", 32'(acc_rd_cyc - acc_wr_cyc), 3);
      chk("s5_rdata", 32'(rv_data), 32'h33);

      // Reset in READ_WAIT with a write queued: both are discarded.
      do_rd(14'h3800);
      cpu_wr = 1; cpu_addr = 14'h0400; cpu_wdata = 8'h44;
      #1;
      chk("s6_wr_ready", 32'(cpu_ready), 1);
      tick();
      cpu_wr = 0;
      rv0 = rv_cnt;
      we0 = we_cnt;
      rst_L = 0;
      #1;
      chk("s6_no_rvalid", 32'(cpu_rvalid), 0);
      chk("s6_empty", 32'(fifo_empty), 1);
`ifdef VDP_ARB_STATS_EN
      chk("s6_stall_clear", 32'(stall_cnt), 0);
`endif
      repeat (2) tick();
      rst_L = 1;
      repeat (6) tick();
      chk("s6_rvalid_count", 32'(rv_cnt - rv0), 0);
      chk("s6_write_count", 32'(we_cnt - we0), 0);
      chk("s6_ram", 32'(ram[14'h0400]), 0);

      // Final VRAM image.
      chk("ram_3800", 32'(ram[14'h3800]), 32'h5A);
      chk("ram_0010", 32'(ram[14'h0010]), 32'h11);
      for (int k = 0; k < 4; k++) chk("ram_s3", 32'(ram[14'h0100 + 14'(k)]), 32'hA0 + k);
      chk("ram_rejected", 32'(ram[14'h0104]), 0);
      chk("ram_0300", 32'(ram[14'h0300]), 32'h33);
      chk("no_loss", 32'(mq.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vdp_vram_arbiter.md
VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the posted-write FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-002 Ports SHALL be as follows, clock and reset first:
- clk, input, 1: 25 MHz clock.
- rst_L, input, 1: reset, asynchronous, active-low.
- disp_go, input, 1: display/sprite VRAM read slot this cycle (OR of bg and sprite go).
- screen_busy, input, 1: display fetch window active.
- cpu_wr, input, 1: CPU write request.
- cpu_rd, input, 1: CPU read request.
- cpu_addr, input, 14: CPU VRAM address.
- cpu_wdata, input, 8: CPU write data.
- cpu_ready, output, 1: request accepted this cycle.
- cpu_rvalid, output, 1: read data valid pulse.
- cpu_rdata, output, 8: read data.
- vram_en, output, 1: CPU-side VRAM port access.
- vram_we, output, 1: write strobe.
- vram_addr, output, 14: port address.
- vram_wdata, output, 8: port write data.
- vram_rdata, input, 8: port read data, 1-cycle latency.
- fifo_full, output, 1: posted-write FIFO full.
- fifo_empty, output, 1: posted-write FIFO empty.

Function
REQ-003 Display access SHALL have absolute priority: vram_en SHALL be 0 in every cycle where disp_go=1.
REQ-004 A write request SHALL be accepted (cpu_ready=1 for that cycle) when the FIFO is not full; {addr,data} SHALL be pushed at that clock edge.
REQ-005 A read request SHALL be accepted only when the FIFO is empty, the FSM is in IDLE and disp_go=0, so that reads observe every earlier write.
REQ-006 If cpu_wr and cpu_rd are asserted in the same cycle, the write SHALL win and the read SHALL stay pending.
REQ-007 FSM states SHALL be IDLE, WRITE, READ, READ_WAIT.
- IDLE->WRITE: FIFO not empty and disp_go=0.
- IDLE->READ: read accepted per REQ-005.
- WRITE: vram_en=1, vram_we=1, pop head; ->WRITE if more entries and disp_go=0 next, else ->IDLE.
- READ: vram_en=1, vram_we=0; ->READ_WAIT.
- READ_WAIT: capture vram_rdata, cpu_rvalid=1 for exactly 1 cycle; ->IDLE.
REQ-008 Read latency SHALL be 2 cycles from acceptance to the cpu_rvalid pulse.
REQ-009 If disp_go rises while in WRITE, the pop SHALL be suppressed: vram_en=0 and the entry retained; state returns to IDLE.
REQ-010 A read in progress SHALL complete; disp_go during READ_WAIT SHALL NOT affect it, because the port was already issued.
REQ-011 Simultaneous push and pop when full SHALL be rejected (cpu_ready=0); simultaneous push and pop when non-full SHALL keep the count correct.
REQ-012 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
- full: MSBs differ and the rest are equal.
- empty: pointers are equal.
REQ-013 screen_busy=0 SHALL allow back-to-back pops, one per cycle; screen_busy has no other effect in this block.

Reset
REQ-014 While rst_L=0, the FSM SHALL be in IDLE, the pointers SHALL be 0, and fifo_empty=1.
REQ-015 While rst_L=0, all other outputs SHALL be 0 and cpu_rdata=8'h00.
REQ-016 Reset during WRITE or READ SHALL discard the pending FIFO contents and any outstanding read; no cpu_rvalid SHALL follow.

Configuration
REQ-017 With macro VDP_ARB_STATS_EN defined, the block SHALL add output stall_cnt[15:0].
- It counts cycles with FIFO not empty and disp_go=1.
- It saturates at 16'hFFFF.
- It clears on reset.
REQ-018 Without VDP_ARB_STATS_EN, the port and its logic SHALL be absent.

Structure
REQ-019 Package vdp_pkg SHALL hold:
- the arb_state_t enum;
- VRAM_AW=14 and VRAM_DW=8;
- the write-entry struct {addr, data}.
REQ-020 The posted-write FIFO SHALL be sub-module vdp_wr_fifo, parameterised by FIFO_DEPTH.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Write 0x3800<-0x5A with disp_go=0 -> vram_we=1 at 0x3800/0x5A 2 cycles after acceptance.
- Write 0x0010<-0x11 then read 0x0010 -> read waits for the FIFO to drain; cpu_rvalid with cpu_rdata=0x11 2 cycles after read acceptance.
- disp_go held high 10 cycles with 5 writes -> 4 accepted, 5th sees cpu_ready=0; vram_en=0 throughout; drain in 4 consecutive cycles after release.
- disp_go rises during a WRITE pop -> entry retained and written once later; no duplicate and no loss.
- Simultaneous cpu_wr and cpu_rd -> write accepted, read accepted after the drain.
- Reset asserted in READ_WAIT -> no cpu_rvalid, fifo_empty=1, stall_cnt=0 (when VDP_ARB_STATS_EN is defined).
